// File: rtl/pad_bank_pkg.sv
// Shared types and constants for the pad bank controller.
// Lane state encoding, turnaround counter width and default parameter values.
package pad_bank_pkg;

  // Wide enough for TURN_CYCLES + SYNC_STAGES up to 19.
  localparam int unsigned CntW = 5;

  localparam int unsigned DefNpads      = 8;
  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefTurnCycles = 1;

  typedef enum logic [1:0] {
    StIn,
    StTurnOut,
    StOut,
    StTurnIn
  } lane_state_e;

endpackage

// File: rtl/pad_bank_lane.sv
// One pad lane: direction FSM with turnaround gap, return-path synchronizer,
// edge detection and a sticky status bit. Open-drain mode under PAD_BANK_OPEN_DRAIN_EN.
module pad_bank_lane
  import pad_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned TURN_CYCLES = DefTurnCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic drive_dir,
  input  logic drive_data,
`ifdef PAD_BANK_OPEN_DRAIN_EN
  input  logic od_mode,
`endif
  output logic pad_oen,
  output logic pad_data,
  input  logic pad_ret,
  output logic sync_val,
  input  logic rise_en,
  input  logic fall_en,
  input  logic clr,
  output logic status
);

  localparam logic [CntW-1:0] TurnOutLoad = CntW'(TURN_CYCLES);
  localparam logic [CntW-1:0] TurnInLoad  = CntW'(TURN_CYCLES + SYNC_STAGES);

  lane_state_e            state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   oen_q, oen_d;
  logic                   data_q, data_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   status_q, status_d;
  logic                   rise, fall, qual;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIn: begin
        if (drive_dir) begin
          state_d = StTurnOut;
          cnt_d   = TurnOutLoad;
        end
      end
      StTurnOut: begin
        if (!drive_dir) begin
          state_d = StIn;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = StOut;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StOut: begin
        if (!drive_dir) begin
          state_d = StTurnIn;
          cnt_d   = TurnInLoad;
        end
      end
      StTurnIn: begin
        // The full gap always elapses, even if the request flips back.
        if (cnt_q == '0) begin
          if (drive_dir) begin
            state_d = StTurnOut;
            cnt_d   = TurnOutLoad;
          end else begin
            state_d = StIn;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIn;
        cnt_d   = '0;
      end
    endcase
  end

  // Pad controls derive from the next state so OEN changes on the deciding edge.
  always_comb begin
    oen_d  = 1'b1;
    data_d = drive_data;
    if (state_d == StOut) begin
`ifdef PAD_BANK_OPEN_DRAIN_EN
      if (od_mode) begin
        oen_d  = drive_data;
        data_d = 1'b0;
      end else begin
        oen_d = 1'b0;
      end
`else
      oen_d = 1'b0;
`endif
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign rise     = sync_val & ~prev_q;
  assign fall     = ~sync_val & prev_q;
  // Edges count only once prev holds a real synchronized sample and the pad is released.
  assign qual     = (state_q == StIn) & vld_q[SYNC_STAGES];

  always_comb begin
    status_d = (status_q & ~clr) | (qual & ((rise & rise_en) | (fall & fall_en)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIn;
      cnt_q    <= '0;
      oen_q    <= 1'b1;
      data_q   <= 1'b0;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      vld_q    <= '0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oen_q    <= oen_d;
      data_q   <= data_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pad_ret};
      prev_q   <= sync_val;
      vld_q    <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      status_q <= status_d;
    end
  end

  assign pad_oen  = oen_q;
  assign pad_data = data_q;
  assign status   = status_q;

endmodule

// File: rtl/pad_bank_ctrl.sv
// Core-side controller for a bank of bidirectional pads: one lane per pad plus irq OR.
// Optional open-drain drive per pad when PAD_BANK_OPEN_DRAIN_EN is defined (adds od_i).
module pad_bank_ctrl
  import pad_bank_pkg::*;
#(
  parameter int unsigned NPADS       = DefNpads,
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned TURN_CYCLES = DefTurnCycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPADS-1:0] dir_i,
  input  logic [NPADS-1:0] out_i,
`ifdef PAD_BANK_OPEN_DRAIN_EN
  input  logic [NPADS-1:0] od_i,
`endif
  output logic [NPADS-1:0] pad_oen_o,
  output logic [NPADS-1:0] pad_i_o,
  input  logic [NPADS-1:0] pad_o_i,
  output logic [NPADS-1:0] in_o,
  input  logic [NPADS-1:0] rise_en_i,
  input  logic [NPADS-1:0] fall_en_i,
  input  logic [NPADS-1:0] irq_clr_i,
  output logic [NPADS-1:0] irq_status_o,
  output logic             irq_o
);

  for (genvar g = 0; g < NPADS; g++) begin : g_lane
    pad_bank_lane #(
      .SYNC_STAGES(SYNC_STAGES),
      .TURN_CYCLES(TURN_CYCLES)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .drive_dir  (dir_i[g]),
      .drive_data (out_i[g]),
`ifdef PAD_BANK_OPEN_DRAIN_EN
      .od_mode    (od_i[g]),
`endif
      .pad_oen    (pad_oen_o[g]),
      .pad_data   (pad_i_o[g]),
      .pad_ret    (pad_o_i[g]),
      .sync_val   (in_o[g]),
      .rise_en    (rise_en_i[g]),
      .fall_en    (fall_en_i[g]),
      .clr        (irq_clr_i[g]),
      .status     (irq_status_o[g])
    );
  end

  // OR of flopped status bits; no extra stage so irq tracks status exactly.
  assign irq_o = |irq_status_o;

endmodule

// File: tb/tb_pad_bank_ctrl.sv
// Self-checking bench for pad_bank_ctrl: reset, a lane-0 vector table, corner-case
// sequences and randomized traffic against a behavioural reference model.
module tb_pad_bank_ctrl;

  localparam int unsigned NPADS = 8;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned TURN  = 1;

  localparam int PhIn = 0, PhToOut = 1, PhOut = 2, PhToIn = 3;

  logic             clk, rst;
  logic [NPADS-1:0] dir, dout, pad, ren, fen, clr, od;
  logic [NPADS-1:0] oen, padi, din, stat;
  logic             irq;

  pad_bank_ctrl #(
    .NPADS      (NPADS),
    .SYNC_STAGES(SYNC),
    .TURN_CYCLES(TURN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dir_i       (dir),
    .out_i       (dout),
`ifdef PAD_BANK_OPEN_DRAIN_EN
    .od_i        (od),
`endif
    .pad_oen_o   (oen),
    .pad_i_o     (padi),
    .pad_o_i     (pad),
    .in_o        (din),
    .rise_en_i   (ren),
    .fall_en_i   (fen),
    .irq_clr_i   (clr),
    .irq_status_o(stat),
    .irq_o       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int               phase [NPADS];
  int               left  [NPADS];
  logic [NPADS-1:0] padhist [16];
  logic [NPADS-1:0] m_in, m_prev, m_stat, m_oen, m_padi;
  int               ec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NPADS; n++) begin
      phase[n] = PhIn;
      left[n]  = 0;
    end
    for (int i = 0; i < 16; i++) padhist[i] = '0;
    m_in = '0; m_prev = '0; m_stat = '0; m_oen = '1; m_padi = '0;
    ec = 0;
  endtask

  task automatic model_step();
    logic [NPADS-1:0] rise, fall, setv;
    logic             warm;
    warm = (ec >= int'(SYNC) + 1);
    rise = m_in & ~m_prev;
    fall = ~m_in & m_prev;
    setv = '0;
    for (int n = 0; n < NPADS; n++)
      if (phase[n] == PhIn && warm)
        setv[n] = (rise[n] & ren[n]) | (fall[n] & fen[n]);
    m_stat = setv | (m_stat & ~clr);
    m_prev = m_in;
    ec++;
    padhist[ec % 16] = pad;
    // Value present before edge k shows up after edge k+SYNC-1.
    m_in = (ec >= int'(SYNC)) ? padhist[(ec - int'(SYNC) + 1) % 16] : '0;
    for (int n = 0; n < NPADS; n++) begin
      case (phase[n])
        PhIn: if (dir[n]) begin phase[n] = PhToOut; left[n] = TURN; end
        PhToOut: begin
          if (!dir[n]) phase[n] = PhIn;
          else if (left[n] == 0) phase[n] = PhOut;
          else left[n]--;
        end
        PhOut: if (!dir[n]) begin phase[n] = PhToIn; left[n] = TURN + SYNC; end
        default: begin
          if (left[n] > 0) left[n]--;
          else if (dir[n]) begin phase[n] = PhToOut; left[n] = TURN; end
          else phase[n] = PhIn;
        end
      endcase
      m_padi[n] = dout[n];
      m_oen[n]  = (phase[n] != PhOut);
`ifdef PAD_BANK_OPEN_DRAIN_EN
      if (phase[n] == PhOut && od[n]) begin
        m_padi[n] = 1'b0;
        m_oen[n]  = dout[n];
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct packed {
    logic dir, out, pad, ren, fen, clr;
    logic e_oen, e_padi, e_in, e_st;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // dir out pad ren fen clr _ oen padi in st   (lane 0, after the edge)
    tbl[0]  = 10'b111000_1110;
    tbl[1]  = 10'b111000_1110;
    tbl[2]  = 10'b111000_0110;
    tbl[3]  = 10'b100110_0010;
    tbl[4]  = 10'b111110_0100;
    tbl[5]  = 10'b010100_1110;
    tbl[6]  = 10'b000100_1000;
    tbl[7]  = 10'b001100_1000;
    tbl[8]  = 10'b001100_1010;
    tbl[9]  = 10'b001100_1010;
    tbl[10] = 10'b000100_1010;
    tbl[11] = 10'b001100_1000;
    tbl[12] = 10'b001100_1010;
    tbl[13] = 10'b001100_1011;
    tbl[14] = 10'b001101_1010;

    rst = 1'b1;
    dir = '0; dout = '0; pad = '1; ren = '1; fen = '1; clr = '0; od = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_oen", oen, 8'hFF);
    chk("reset_padi", padi, 8'h00);
    chk("reset_in", din, 8'h00);
    chk("reset_stat", stat, 8'h00);
    chk("reset_irq", irq, 0);
    rst = 1'b0;
    model_reset();

    tick();
    chk("sync_fill1", din, 8'h00);
    tick();
    chk("sync_fill2", din, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_startup_irq", stat, 8'h00);
    end
    ren = '0; fen = '0;
    tick();

    // Lane 0 direction turn, loopback masking and turn-in masking
    for (int i = 0; i < 15; i++) begin
      dir  = {7'h00, tbl[i].dir};
      dout = {7'h00, tbl[i].out};
      pad  = {7'h7F, tbl[i].pad};
      ren  = {7'h00, tbl[i].ren};
      fen  = {7'h00, tbl[i].fen};
      clr  = {7'h00, tbl[i].clr};
      tick();
      chk($sformatf("tbl%0d_oen", i), oen[0], tbl[i].e_oen);
      chk($sformatf("tbl%0d_padi", i), padi[0], tbl[i].e_padi);
      chk($sformatf("tbl%0d_in", i), din[0], tbl[i].e_in);
      chk($sformatf("tbl%0d_st", i), stat[0], tbl[i].e_st);
      chk($sformatf("tbl%0d_irq", i), irq, tbl[i].e_st);
    end
    dir = '0; dout = '0; pad = '1; ren = '0; fen = '0; clr = '0;
    repeat (3) tick();

    // Lane 3: set and clear in the same cycle, set wins
    ren = 8'h08;
    pad = 8'hF7;
    repeat (3) tick();
    chk("l3_quiet", stat, 8'h00);
    pad = 8'hFF;
    tick();
    tick();
    chk("l3_not_yet", stat, 8'h00);
    clr = 8'h08;
    tick();
    chk("l3_set_wins", stat, 8'h08);
    chk("l3_irq", irq, 1);
    clr = 8'h00; ren = 8'h00;
    tick();
    chk("l3_en_off_holds", stat, 8'h08);
    clr = 8'h08;
    tick();
    chk("l3_cleared", stat, 8'h00);
    chk("l3_irq_low", irq, 0);
    clr = 8'h00;

    // Lane 2: one-cycle direction pulse never drives
    dir = 8'h04;
    tick();
    chk("l2_pulse_oen0", oen, 8'hFF);
    dir = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("l2_pulse_oen", oen, 8'hFF);
    end
    fen = 8'h04;
    pad = 8'hFB;
    tick();
    tick();
    chk("l2_fall_pending", stat, 8'h00);
    tick();
    chk("l2_back_in_in", stat, 8'h04);
    fen = 8'h00; pad = 8'hFF; clr = 8'h04;
    tick();
    clr = 8'h00;
    repeat (3) tick();

`ifdef PAD_BANK_OPEN_DRAIN_EN
    // Lane 1 open drain: drive low only, release for high
    od = 8'h02; dir = 8'h02; dout = 8'h00;
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      dout = (i % 2 == 1) ? 8'h02 : 8'h00;
      tick();
      chk("od_padi", padi[1], 0);
      chk("od_oen", oen[1], dout[1]);
    end
    dir = '0; od = '0; dout = '0;
    repeat (6) tick();
`endif

    // Asynchronous reset mid-drive releases pads without a clock
    dir = 8'h20; dout = 8'h20;
    repeat (4) tick();
    chk("l5_driving", oen, 8'hDF);
    chk("l5_data", padi, 8'h20);
    #2 rst = 1'b1;
    #1;
    chk("async_oen", oen, 8'hFF);
    chk("async_padi", padi, 8'h00);
    chk("async_in", din, 8'h00);
    dir = '0; dout = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (5) tick();
    chk("post_reset_model", oen, m_oen);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      dir  = dir ^ NPADS'($urandom & $urandom & $urandom);
      dout = NPADS'($urandom);
      pad  = pad ^ NPADS'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) ren = NPADS'($urandom);
      if ($urandom_range(0, 15) == 0) fen = NPADS'($urandom);
      if ($urandom_range(0, 31) == 0) od = NPADS'($urandom);
      clr = NPADS'($urandom & $urandom & $urandom);
      tick();
      chk("rnd_oen", oen, m_oen);
      chk("rnd_padi", padi, m_padi);
      chk("rnd_in", din, m_in);
      chk("rnd_stat", stat, m_stat);
      chk("rnd_irq", irq, |m_stat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
